wb_slave_timeout: RTL and testbench

//  Per-slave-port watchdog placed between one interconnect slave port (sN) and the attached slave.

---
 rtl/wb_slave_timeout.sv | 125 ++++++++++++
 tb/tb_wb_slave_timeout.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_timeout.sv
// Wishbone per-slave-port watchdog: zero-latency passthrough that aborts a stalled beat with ERR.
// Optional abort status outputs are enabled with `define WB_SLAVE_TIMEOUT_STATUS_EN.
module wb_slave_timeout #(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       m_cyc,
  input  logic                       m_stb,
  input  logic                       m_we,
  input  logic [WB_ADDR_WIDTH-1:0]   m_adr,
  input  logic [WB_DATA_WIDTH-1:0]   m_dat_w,
  input  logic [WB_DATA_WIDTH/8-1:0] m_sel,
  input  logic [2:0]                 m_cti,
  input  logic [1:0]                 m_bte,
  output logic [WB_DATA_WIDTH-1:0]   m_dat_r,
  output logic                       m_ack,
  output logic                       m_err,
  output logic                       s_cyc,
  output logic                       s_stb,
  output logic                       s_we,
  output logic [WB_ADDR_WIDTH-1:0]   s_adr,
  output logic [WB_DATA_WIDTH-1:0]   s_dat_w,
  output logic [WB_DATA_WIDTH/8-1:0] s_sel,
  output logic [2:0]                 s_cti,
  output logic [1:0]                 s_bte,
  input  logic [WB_DATA_WIDTH-1:0]   s_dat_r,
  input  logic                       s_ack,
  input  logic                       s_err
`ifdef WB_SLAVE_TIMEOUT_STATUS_EN
  ,
  output logic [15:0]                to_count,
  output logic [WB_ADDR_WIDTH-1:0]   to_adr,
  output logic                       to_irq
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] ABORT  = 2'd2;
  localparam logic [1:0] DRAIN  = 2'd3;

  generate
    if (TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("wb_slave_timeout: TIMEOUT_CYCLES must be >= 2");
    end
  endgenerate

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [CNT_W-1:0] cnt;
  logic             stalled;
  logic             timeout_hit;
  logic             passthrough;

  assign stalled     = m_cyc & m_stb & ~s_ack & ~s_err;
  assign timeout_hit = (state == ACTIVE) & stalled & (cnt == CNT_LAST);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (m_cyc && m_stb) next_state = ACTIVE;
      ACTIVE:  if (!m_cyc) next_state = IDLE;
               else if (timeout_hit) next_state = ABORT;
      ABORT:   next_state = m_cyc ? DRAIN : IDLE;
      DRAIN:   if (!m_cyc) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  // The IDLE cycle that first sees STB also counts, so ERR lands exactly TIMEOUT_CYCLES after it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      cnt <= '0;
    else if ((state == IDLE || state == ACTIVE) && stalled && !timeout_hit)
      cnt <= cnt + CNT_W'(1);
    else
      cnt <= '0;
  end

  assign passthrough = rstn & ((state == IDLE) | (state == ACTIVE));

  always_comb begin
    s_cyc = passthrough & m_cyc;
    s_stb = passthrough & m_stb;
    m_ack = passthrough & s_ack;
    m_err = rstn & ((state == ABORT) | (passthrough & s_err));
  end

  assign s_we    = m_we;
  assign s_adr   = m_adr;
  assign s_dat_w = m_dat_w;
  assign s_sel   = m_sel;
  assign s_cti   = m_cti;
  assign s_bte   = m_bte;
  assign m_dat_r = s_dat_r;

`ifdef WB_SLAVE_TIMEOUT_STATUS_EN
  // Status registers update on the edge entering ABORT so they are valid during the ERR cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_count <= '0;
      to_adr   <= '0;
      to_irq   <= 1'b0;
    end else begin
      to_irq <= timeout_hit;
      if (timeout_hit) begin
        to_adr <= m_adr;
        if (to_count != 16'hFFFF) to_count <= to_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_slave_timeout.sv
// Self-checking bench for wb_slave_timeout: randomized traffic against a stall-count model,
// plus directed literal checks of the timeout boundaries.
module tb_wb_slave_timeout;

  localparam int T  = 16;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0;
  logic [AW-1:0] m_adr = '0;
  logic [DW-1:0] m_dat_w = '0;
  logic [3:0]    m_sel = '0;
  logic [2:0]    m_cti = '0;
  logic [1:0]    m_bte = '0;
  logic [DW-1:0] s_dat_r = '0;
  logic          s_ack = 1'b0, s_err = 1'b0;
  logic [DW-1:0] m_dat_r;
  logic          m_ack, m_err, s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat_w;
  logic [3:0]    s_sel;
  logic [2:0]    s_cti;
  logic [1:0]    s_bte;

  logic          m_cyc2 = 1'b0, m_stb2 = 1'b0;
  logic [DW-1:0] m_dat_r2;
  logic          m_ack2, m_err2, s_cyc2, s_stb2, s_we2;
  logic [AW-1:0] s_adr2;
  logic [DW-1:0] s_dat_w2;
  logic [3:0]    s_sel2;
  logic [2:0]    s_cti2;
  logic [1:0]    s_bte2;

`ifdef WB_SLAVE_TIMEOUT_STATUS_EN
  logic [15:0]   to_count, to_count2;
  logic [AW-1:0] to_adr, to_adr2;
  logic          to_irq, to_irq2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_slave_timeout #(.WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) u_dut (
    .clk(clk), .rstn(rstn),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_w(m_dat_w),
    .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte), .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w),
    .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte), .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err)
`ifdef WB_SLAVE_TIMEOUT_STATUS_EN
    , .to_count(to_count), .to_adr(to_adr), .to_irq(to_irq)
`endif
  );

  // Second instance at the minimum timeout, driven only by its own CYC/STB with a dead slave.
  wb_slave_timeout #(.WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(2)) u_dut2 (
    .clk(clk), .rstn(rstn),
    .m_cyc(m_cyc2), .m_stb(m_stb2), .m_we(m_we), .m_adr(m_adr), .m_dat_w(m_dat_w),
    .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte), .m_dat_r(m_dat_r2), .m_ack(m_ack2), .m_err(m_err2),
    .s_cyc(s_cyc2), .s_stb(s_stb2), .s_we(s_we2), .s_adr(s_adr2), .s_dat_w(s_dat_w2),
    .s_sel(s_sel2), .s_cti(s_cti2), .s_bte(s_bte2), .s_dat_r(s_dat_r), .s_ack(1'b0), .s_err(1'b0)
`ifdef WB_SLAVE_TIMEOUT_STATUS_EN
    , .to_count(to_count2), .to_adr(to_adr2), .to_irq(to_irq2)
`endif
  );

  task automatic checkBit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of master/slave activity just after the rising edge.
  task automatic applyStimulus(input logic cyc, input logic stb, input logic ack, input logic err,
                               input logic [AW-1:0] adr, input logic [DW-1:0] datr);
    @(posedge clk);
    #1;
    m_cyc   = cyc;
    m_stb   = stb;
    s_ack   = ack;
    s_err   = err;
    m_adr   = adr;
    s_dat_r = datr;
    m_we    = 1'($urandom_range(0, 1));
    m_dat_w = $urandom;
    m_sel   = 4'($urandom_range(0, 15));
    m_bte   = 2'($urandom_range(0, 3));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Reference model: a beat that stays stalled for T consecutive cycles is answered by one ERR
  // cycle, after which the slave stays hidden until the master ends the bus cycle.
  int unsigned   mdl_stall = 0;
  bit            mdl_abort = 1'b0;
  bit            mdl_iso = 1'b0;
  int unsigned   mdl_naborts = 0;
  logic [AW-1:0] mdl_last_adr = '0;
  logic          e_scyc, e_sstb, e_ack, e_err, e_irq;

  always @(negedge clk) begin
    e_irq = 1'b0;
    if (!rstn) begin
      e_scyc = 1'b0; e_sstb = 1'b0; e_ack = 1'b0; e_err = 1'b0;
    end else if (mdl_abort) begin
      e_scyc = 1'b0; e_sstb = 1'b0; e_ack = 1'b0; e_err = 1'b1; e_irq = 1'b1;
    end else if (mdl_iso) begin
      e_scyc = 1'b0; e_sstb = 1'b0; e_ack = 1'b0; e_err = 1'b0;
    end else begin
      e_scyc = m_cyc; e_sstb = m_stb; e_ack = s_ack; e_err = s_err;
    end
    checkBit("s_cyc", s_cyc, e_scyc);
    checkBit("s_stb", s_stb, e_sstb);
    checkBit("m_ack", m_ack, e_ack);
    checkBit("m_err", m_err, e_err);
    checkOutput("m_dat_r", m_dat_r, s_dat_r);
    checkOutput("s_adr", s_adr, m_adr);
    checkOutput("s_dat_w", s_dat_w, m_dat_w);
    checkOutput("s_ctl", {22'b0, s_we, s_sel, s_cti, s_bte}, {22'b0, m_we, m_sel, m_cti, m_bte});
`ifdef WB_SLAVE_TIMEOUT_STATUS_EN
    checkBit("to_irq", to_irq, e_irq);
    checkOutput("to_count", {16'b0, to_count}, (mdl_naborts > 65535) ? 32'hFFFF : mdl_naborts);
    checkOutput("to_adr", to_adr, mdl_last_adr);
`endif
    if (!rstn) begin
      mdl_stall = 0; mdl_abort = 1'b0; mdl_iso = 1'b0;
      mdl_naborts = 0; mdl_last_adr = '0;
    end else if (mdl_abort) begin
      mdl_abort = 1'b0;
      mdl_iso   = m_cyc;
    end else if (mdl_iso) begin
      mdl_iso = m_cyc;
    end else if (m_cyc && m_stb && !s_ack && !s_err) begin
      if (mdl_stall == T - 1) begin
        mdl_abort = 1'b1;
        mdl_stall = 0;
        mdl_naborts++;
        mdl_last_adr = m_adr;
      end else begin
        mdl_stall++;
      end
    end else begin
      mdl_stall = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  int waits[4];
  int irq_seen;

  initial begin
    $display("[TB] starting wb_slave_timeout bench");
    #1;
    checkBit("rst_s_cyc", s_cyc, 1'b0);
    checkBit("rst_m_err", m_err, 1'b0);
    idle(2);
    rstn = 1'b1;
    idle(2);

    // Single read, ACK after 3 wait states.
    for (int k = 0; k <= 3; k++) begin
      applyStimulus(1'b1, 1'b1, k == 3, 1'b0, 32'h40, (k == 3) ? 32'hCAFE0001 : 32'h0);
      #2;
      checkBit("t1_ack", m_ack, k == 3);
      checkBit("t1_err", m_err, 1'b0);
      if (k == 3) checkOutput("t1_dat_r", m_dat_r, 32'hCAFE0001);
    end
    idle(2);

    // Dead slave: ERR in cycle 16, isolation, masked late ACK in DRAIN, then back to passthrough.
    for (int k = 0; k <= 20; k++) begin
      applyStimulus(k != 19, (k != 19), k == 18, 1'b0, 32'h80, 32'h0);
      #2;
      checkBit("t2_err", m_err, k == 16);
      checkBit("t2_s_cyc", s_cyc, (k < 16) || (k == 20));
      if (k == 18) checkBit("t2_drain_ack", m_ack, 1'b0);
    end
    idle(2);

    // ACK on the terminal cycle wins over the timeout.
    for (int k = 0; k <= 15; k++) begin
      applyStimulus(1'b1, 1'b1, k == 15, 1'b0, 32'hC0, 32'h5);
      #2;
      checkBit("t3_ack", m_ack, k == 15);
      checkBit("t3_err", m_err, 1'b0);
    end
    idle(2);

    // Incrementing bursts: 12 waits per beat pass; a 16-wait third beat aborts.
    for (int burst = 0; burst < 2; burst++) begin
      waits = '{12, 12, (burst == 0) ? 12 : 16, 12};
      for (int b = 0; b < 4; b++) begin
        m_cti = (b == 3) ? 3'b111 : 3'b010;
        if (waits[b] < T) begin
          for (int j = 0; j <= waits[b]; j++) begin
            applyStimulus(1'b1, 1'b1, j == waits[b], 1'b0, 32'h100 + 32'(4 * b), 32'(b));
            #2;
            checkBit("t4_ack", m_ack, j == waits[b]);
            checkBit("t4_err", m_err, 1'b0);
          end
        end else begin
          for (int j = 0; j <= T; j++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h100 + 32'(4 * b), 32'(b));
            #2;
            checkBit("t4_abort_err", m_err, j == T);
          end
          break;
        end
      end
      m_cti = 3'b000;
      idle(2);
    end

    // Async reset in cycle 8 of a stall, then a fresh full-length timeout.
    for (int k = 0; k <= 8; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
      if (k == 8) rstn = 1'b0;
      #2;
      checkBit("t5_s_cyc", s_cyc, k < 8);
      checkBit("t5_s_stb", s_stb, k < 8);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    rstn = 1'b1;
    for (int k = 0; k <= T + 1; k++) begin
      applyStimulus(k <= T, k <= T, 1'b0, 1'b0, 32'h240, 32'h0);
      #2;
      checkBit("t5_err", m_err, k == T);
    end
    idle(2);

    // Minimum timeout instance: ERR in cycle 2.
    for (int k = 0; k <= 4; k++) begin
      @(posedge clk);
      #1;
      m_cyc2 = (k < 4);
      m_stb2 = (k < 4);
      #2;
      checkBit("t6_min_err", m_err2, k == 2);
      checkBit("t6_min_s_cyc", s_cyc2, k < 2);
    end

`ifdef WB_SLAVE_TIMEOUT_STATUS_EN
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    rstn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    rstn = 1'b1;
    irq_seen = 0;
    for (int n = 1; n <= 3; n++) begin
      for (int k = 0; k <= T + 1; k++) begin
        applyStimulus(k <= T, k <= T, 1'b0, 1'b0, 32'(n) << 12, 32'h0);
        #2;
        if (to_irq) irq_seen++;
      end
    end
    checkOutput("t6_to_count", {16'b0, to_count}, 32'd3);
    checkOutput("t6_to_adr", to_adr, 32'h3000);
    checkOutput("t6_irq_pulses", irq_seen, 32'd3);
    idle(2);
`endif

    // Randomized traffic with varying slave responsiveness and occasional resets.
    for (int t = 0; t < 300; t++) begin
      int len, mode, p_ack;
      idle($urandom_range(0, 3));
      len  = $urandom_range(1, 40);
      mode = $urandom_range(0, 3);
      p_ack = (mode == 0) ? 0 : (mode == 1) ? 20 : (mode == 2) ? 4 : 2;
      for (int c = 0; c < len; c++) begin
        logic ack, err;
        ack = (p_ack != 0) && ($urandom_range(0, p_ack - 1) == 0);
        err = ($urandom_range(0, 29) == 0);
        applyStimulus(1'b1, $urandom_range(0, 7) != 0, ack, err, $urandom, $urandom);
        rstn = ($urandom_range(0, 199) != 0);
      end
      rstn = 1'b1;
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
